// File: rtl/one_wire_rom_collector.sv
// Assembles a NUM_BYTES frame from the 1-Wire RX byte stream and checks it with the
// Dallas/Maxim CRC-8. A bus reset, a clear request or an inter-byte timeout aborts the frame.
module one_wire_rom_collector #(
  parameter int NUM_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_byte,
  input  logic                           presence_detect,
  input  logic                           clear,
  output logic [NUM_BYTES*8-1:0]         rom_id,
  output logic [7:0]                     family_code,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt,
  output logic                           id_valid,
  output logic                           frame_done,
  output logic                           crc_ok,
  output logic                           timeout
);

  localparam int CW = $clog2(NUM_BYTES+1);
  localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST    = CW'(NUM_BYTES-1);
  localparam logic [GW-1:0] GAP_MAX = GW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES-1 : 0);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_BYTES*8-1:0] rom_q, rom_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             crc_q, crc_d, crc_nxt;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   pres_q;
  logic                   id_valid_q, id_valid_d;
  logic                   done_q, done_d;
  logic                   ok_q, ok_d;
  logic                   to_q, to_d;
  logic                   pres_rise;

  // Whole byte per cycle, LSB first, reflected polynomial x^8+x^5+x^4+1.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  always_comb begin
    pres_rise  = presence_detect & ~pres_q;
    state_d    = state_q;
    rom_d      = rom_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    gap_d      = gap_q;
    done_d     = done_q;
    ok_d       = ok_q;
    id_valid_d = 1'b0;
    to_d       = 1'b0;
    // A new frame always seeds the CRC from zero.
    crc_nxt    = crc8_byte((state_q == COLLECT) ? crc_q : 8'h00, rx_byte);

    if (clear || pres_rise) begin
      state_d = IDLE;
      rom_d   = '0;
      cnt_d   = '0;
      crc_d   = 8'h00;
      gap_d   = '0;
      done_d  = 1'b0;
      ok_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (rx_valid) begin
            rom_d[7:0] = rx_byte;
            crc_d      = crc_nxt;
            cnt_d      = CW'(1);
            gap_d      = '0;
            done_d     = 1'b0;
            ok_d       = 1'b0;
            state_d    = COLLECT;
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            for (int k = 0; k < NUM_BYTES; k++)
              if (cnt_q == CW'(k)) rom_d[k*8 +: 8] = rx_byte;
            crc_d = crc_nxt;
            gap_d = '0;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_d    = DONE;
              id_valid_d = 1'b1;
              done_d     = 1'b1;
              ok_d       = (crc_nxt == 8'h00);
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            // Partial bytes stay visible on rom_id after a timeout.
            if (gap_q == GAP_MAX) begin
              to_d    = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
              crc_d   = 8'h00;
              gap_d   = '0;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_q      <= '0;
      cnt_q      <= '0;
      crc_q      <= 8'h00;
      gap_q      <= '0;
      pres_q     <= 1'b0;
      id_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_q      <= rom_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      gap_q      <= gap_d;
      pres_q     <= presence_detect;
      id_valid_q <= id_valid_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      to_q       <= to_d;
    end
  end

  assign rom_id      = rom_q;
  assign family_code = rom_q[7:0];
  assign byte_cnt    = cnt_q;
  assign id_valid    = id_valid_q;
  assign frame_done  = done_q;
  assign crc_ok      = ok_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_one_wire_rom_collector.sv
// Randomized bench for one_wire_rom_collector: a frame-level model predicts completed
// frames and timeouts into a scoreboard queue; a monitor pops and compares on each pulse.
module tb_one_wire_rom_collector;
  localparam int N  = 8;
  localparam int TO = 20;
  localparam int CW = $clog2(N+1);
  localparam int W  = N*8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          presence_detect = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  rom_id;
  logic [7:0]    family_code;
  logic [CW-1:0] byte_cnt;
  logic          id_valid, frame_done, crc_ok, timeout;

  always #5 clk = ~clk;

  one_wire_rom_collector #(.NUM_BYTES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .presence_detect(presence_detect), .clear(clear), .rom_id(rom_id),
    .family_code(family_code), .byte_cnt(byte_cnt), .id_valid(id_valid),
    .frame_done(frame_done), .crc_ok(crc_ok), .timeout(timeout)
  );

  typedef struct {bit is_to; logic [W-1:0] rom; bit ok;} ev_t;
  ev_t evq[$];
  int  nvec = 0;
  int  nerr = 0;

  // reference model state
  logic [7:0] m_bytes[$];
  logic [7:0] m_rom[N];
  bit         m_coll, m_done, m_ok, m_prev;
  int         m_idle;

  // expectation after the next edge, and the copy valid in the current cycle
  logic [W-1:0] xn_rom, xc_rom;
  int           xn_cnt, xc_cnt;
  bit           xn_done, xc_done, xn_ok, xc_ok, xn_idv, xc_idv, xn_to, xc_to;

  function automatic logic [7:0] frame_crc(input logic [7:0] f[$]);
    logic [7:0] c = 8'h00;
    logic       fb;
    foreach (f[i])
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ f[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 8'h8C;
      end
    return c;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic publish(input bit idv, input bit to);
    for (int k = 0; k < N; k++) xn_rom[k*8 +: 8] = m_rom[k];
    xn_cnt  = m_bytes.size();
    xn_done = m_done;
    xn_ok   = m_ok;
    xn_idv  = idv;
    xn_to   = to;
  endtask

  task automatic model_reset();
    m_bytes.delete();
    foreach (m_rom[k]) m_rom[k] = 8'h00;
    m_coll = 0; m_done = 0; m_ok = 0; m_prev = 0; m_idle = 0;
    evq.delete();
    publish(0, 0);
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit clr, input bit pres);
    bit   pr;
    bit   idv = 0;
    bit   to = 0;
    ev_t  e;
    pr = pres & ~m_prev;
    m_prev = pres;
    if (clr || pr) begin
      m_bytes.delete();
      foreach (m_rom[k]) m_rom[k] = 8'h00;
      m_coll = 0; m_done = 0; m_ok = 0; m_idle = 0;
    end else if (v) begin
      if (!m_coll) begin
        m_bytes.delete();
        m_coll = 1; m_done = 0; m_ok = 0;
      end
      m_rom[m_bytes.size()] = b;
      m_bytes.push_back(b);
      m_idle = 0;
      if (m_bytes.size() == N) begin
        m_coll = 0; m_done = 1;
        m_ok = (frame_crc(m_bytes) == 8'h00);
        idv = 1;
        e.is_to = 0;
        for (int k = 0; k < N; k++) e.rom[k*8 +: 8] = m_rom[k];
        e.ok = m_ok;
        evq.push_back(e);
      end
    end else if (m_coll) begin
      m_idle++;
      if (m_idle == TO) begin
        m_coll = 0;
        m_bytes.delete();
        to = 1;
        e.is_to = 1; e.rom = '0; e.ok = 0;
        evq.push_back(e);
      end
    end
    publish(idv, to);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xc_rom <= '0; xc_cnt <= 0; xc_done <= 0; xc_ok <= 0; xc_idv <= 0; xc_to <= 0;
    end else begin
      xc_rom <= xn_rom; xc_cnt <= xn_cnt; xc_done <= xn_done;
      xc_ok <= xn_ok; xc_idv <= xn_idv; xc_to <= xn_to;
    end
  end

  ev_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      check("byte_cnt", W'(byte_cnt), W'(xc_cnt));
      check("rom_id", rom_id, xc_rom);
      check("frame_done", W'(frame_done), W'(xc_done));
      check("crc_ok", W'(crc_ok), W'(xc_ok));
      check("id_valid_timing", W'(id_valid), W'(xc_idv));
      check("timeout_timing", W'(timeout), W'(xc_to));
      if (id_valid) begin
        if (evq.size() == 0 || evq[0].is_to) begin
          nvec++; nerr++;
          $display("FAIL id_valid_unexpected: got pulse expected none at %0t", $time);
        end else begin
          mon_e = evq.pop_front();
          check("frame_rom", rom_id, mon_e.rom);
          check("frame_crc_ok", W'(crc_ok), W'(mon_e.ok));
          check("family_code", W'(family_code), W'(mon_e.rom[7:0]));
        end
      end
      if (timeout) begin
        if (evq.size() == 0 || !evq[0].is_to) begin
          nvec++; nerr++;
          $display("FAIL timeout_unexpected: got pulse expected none at %0t", $time);
        end else begin
          mon_e = evq.pop_front();
          check("timeout_frame_done", W'(frame_done), W'(0));
        end
      end
    end
  end

  task automatic cyc(input bit v, input logic [7:0] b, input bit clr, input bit pres);
    @(posedge clk);
    #1;
    rx_valid = v; rx_byte = b; clear = clr; presence_detect = pres;
    model_step(v, b, clr, pres);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 8'h00, 0, 0);
  endtask

  task automatic send_frame(input logic [7:0] f[N], input int gap);
    for (int i = 0; i < N; i++) begin
      cyc(1, f[i], 0, 0);
      idle(gap);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rom_id"}, rom_id, '0);
    check({tag, "_family"}, W'(family_code), '0);
    check({tag, "_byte_cnt"}, W'(byte_cnt), '0);
    check({tag, "_pulses"}, W'({id_valid, timeout}), '0);
    check({tag, "_levels"}, W'({frame_done, crc_ok}), '0);
  endtask

  logic [7:0] good[N] = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
  logic [7:0] bad[N];
  logic [7:0] fr[N];
  logic [7:0] tmpq[$];

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    send_frame(good, 3);
    idle(4);
    bad = good; bad[3] = 8'h03;
    send_frame(bad, 3);
    idle(4);

    for (int i = 0; i < 3; i++) cyc(1, good[i], 0, 0);
    idle(TO + 2);
    send_frame(good, 1);
    idle(2);

    for (int i = 0; i < 5; i++) cyc(1, good[i], 0, 0);
    cyc(0, 8'h00, 0, 1);
    idle(2);
    send_frame(good, 0);
    idle(2);
    cyc(1, 8'hFF, 0, 1);
    cyc(0, 8'h00, 0, 0);
    send_frame(good, 2);

    send_frame(good, 0);
    send_frame(good, 0);
    idle(3);

    for (int i = 0; i < 4; i++) cyc(1, good[i], 0, 0);
    cyc(1, 8'h55, 1, 0);
    send_frame(good, 0);
    idle(2);

    for (int i = 0; i < 4; i++) cyc(1, good[i], 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    rx_valid = 0; clear = 0; presence_detect = 0;
    #1 check_zero_outputs("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    send_frame(good, 1);
    idle(3);

    for (int f = 0; f < 200; f++) begin
      tmpq.delete();
      for (int i = 0; i < N-1; i++) begin
        fr[i] = 8'($urandom);
        tmpq.push_back(fr[i]);
      end
      fr[N-1] = frame_crc(tmpq);
      if ($urandom_range(0, 4) == 0) fr[$urandom_range(0, N-1)] ^= 8'(1 << $urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        int r;
        int g;
        r = $urandom_range(0, 99);
        cyc(1, fr[i], r < 2, (r >= 2) && (r < 4));
        g = ($urandom_range(0, 99) < 3) ? TO + 2 : $urandom_range(0, 3);
        idle(g);
      end
    end
    idle(4);
    check("pending_events", W'(evq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end
endmodule
